// File: rtl/srl_fifo_ctl.sv
// srl_fifo_ctl: first-word-fall-through FIFO, DEPTH x 6 bits, built on a
// 16-stage addressable shift register (srl16x6e). New data always enters
// stage 0; the head entry sits at stage addr = count-1 and is read out
// combinationally, so dout is valid whenever empty is low.
// Optional sticky ovf/udf error flags are built only when SRL_FIFO_ERR_EN
// is defined; otherwise they are tied low and err_clr is ignored.

// Single-bit, 16-stage addressable shift register.
module srl16e (
  input  logic       clk,
  input  logic       ce,
  input  logic       d,
  input  logic [3:0] a,
  output logic       q
);
  logic [15:0] sr;

  // Shift on enable; contents are not reset.
  always_ff @(posedge clk)
    if (ce) sr <= {sr[14:0], d};

  assign q = sr[a];
endmodule

// Six bit-slices of srl16e sharing ce and address.
module srl16x6e (
  input  logic       clk,
  input  logic       ce,
  input  logic [5:0] d,
  input  logic [3:0] a,
  output logic [5:0] q
);
  for (genvar b = 0; b < 6; b++) begin : g_bit
    srl16e u_bit (.clk(clk), .ce(ce), .d(d[b]), .a(a), .q(q[b]));
  end
endmodule

module srl_fifo_ctl #(
  parameter int DEPTH      = 16,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [5:0] din,
  input  logic       rd,
  output logic [5:0] dout,
  output logic       empty,
  output logic       full,
  output logic       aempty,
  output logic       afull,
  output logic [4:0] count,
  output logic       ovf,
  output logic       udf,
  input  logic       err_clr
);
  logic       push, pop;
  logic [3:0] addr, addr_nxt;
  logic [4:0] count_nxt;

  assign push = wr & (~full | rd);
  assign pop  = rd & ~empty;

  srl16x6e u_srl (.clk(clk), .ce(push), .d(din), .a(addr), .q(dout));

  // Next occupancy and head address; addr tracks count-1, pinned at 0 when empty.
  always_comb begin
    count_nxt = count;
    addr_nxt  = addr;
    if (push && !pop) begin
      count_nxt = count + 5'd1;
      if (count != 5'd0) addr_nxt = addr + 4'd1;
    end else if (pop && !push) begin
      count_nxt = count - 5'd1;
      if (count != 5'd1) addr_nxt = addr - 4'd1;
    end
  end

  // Counters and status flags, flags registered from the next-state count.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count  <= 5'd0;
      addr   <= 4'd0;
      empty  <= 1'b1;
      full   <= 1'b0;
      aempty <= 1'b1;
      afull  <= 1'b0;
    end else begin
      count  <= count_nxt;
      addr   <= addr_nxt;
      empty  <= (count_nxt == 5'd0);
      full   <= (count_nxt == 5'(DEPTH));
      aempty <= (count_nxt <= 5'(AEMPTY_LVL));
      afull  <= (count_nxt >= 5'(AFULL_LVL));
    end

`ifdef SRL_FIFO_ERR_EN
  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (err_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr && full && !rd) ovf <= 1'b1;
      if (rd && empty)       udf <= 1'b1;
    end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif
endmodule

// File: tb/tb_srl_fifo_ctl.sv
// Directed bench for srl_fifo_ctl; error-flag expectations follow SRL_FIFO_ERR_EN.
module tb_srl_fifo_ctl;
`ifdef SRL_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 0, rst = 1, wr = 0, rd = 0, err_clr = 0;
  logic [5:0] din = 0, dout;
  logic       empty, full, aempty, afull, ovf, udf;
  logic [4:0] count;
  int total = 0, bad = 0;

  srl_fifo_ctl dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .empty(empty), .full(full), .aempty(aempty), .afull(afull),
    .count(count), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns #1 after the edge, inputs idle.
  task automatic cyc(input logic w, input logic [5:0] d, input logic r, input logic c);
    wr = w; din = d; rd = r; err_clr = c;
    @(posedge clk); #1;
    wr = 0; rd = 0; err_clr = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, full, aempty, afull} !== 4'b1010) begin bad++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, aempty, afull}); end
    total++; if ({ovf, udf} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {ovf, udf}); end
    rst = 0;
  endtask

  task automatic test_basic;
    cyc(1, 6'h01, 0, 0);
    total++; if (dout !== 6'h01 || empty !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL basic_first got dout=%h empty=%b count=%0d exp 01/0/1", dout, empty, count); end
    cyc(1, 6'h02, 0, 0);
    cyc(1, 6'h03, 0, 0);
    total++; if (count !== 5'd3 || aempty !== 1'b0 || dout !== 6'h01) begin bad++; $display("FAIL basic_three got count=%0d aempty=%b dout=%h exp 3/0/01", count, aempty, dout); end
    for (int i = 1; i <= 3; i++) begin
      total++; if (dout !== 6'(i)) begin bad++; $display("FAIL basic_read%0d got=%h exp=%h", i, dout, 6'(i)); end
      cyc(0, 6'h00, 1, 0);
    end
    total++; if (empty !== 1'b1 || count !== 5'd0 || aempty !== 1'b1) begin bad++; $display("FAIL basic_empty got empty=%b count=%0d aempty=%b exp 1/0/1", empty, count, aempty); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 16; k++) begin
      cyc(1, 6'(k), 0, 0);
      total++;
      if (count !== 5'(k + 1) || afull !== (k + 1 >= 12) || full !== (k + 1 == 16) || aempty !== (k + 1 <= 2)) begin
        bad++; $display("FAIL fill_%0d got count=%0d afull=%b full=%b aempty=%b", k, count, afull, full, aempty);
      end
    end
    cyc(1, 6'h3F, 0, 0);
    total++; if (count !== 5'd16 || full !== 1'b1 || dout !== 6'h00) begin bad++; $display("FAIL fill_drop got count=%0d full=%b dout=%h exp 16/1/00", count, full, dout); end
    total++; if (ovf !== ERR) begin bad++; $display("FAIL fill_ovf got=%b exp=%b", ovf, ERR); end
    for (int i = 0; i < 16; i++) begin
      total++; if (dout !== 6'(i)) begin bad++; $display("FAIL fill_drain%0d got=%h exp=%h", i, dout, 6'(i)); end
      cyc(0, 6'h00, 1, 0);
    end
    total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL fill_empty got empty=%b count=%0d", empty, count); end
    cyc(0, 6'h00, 0, 1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf_clr got=%b exp=0", ovf); end
  endtask

  task automatic test_full_rw;
    for (int k = 0; k < 16; k++) cyc(1, 6'(k), 0, 0);
    cyc(1, 6'h2A, 1, 0);
    total++; if (dout !== 6'h01 || count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fullrw got dout=%h count=%0d full=%b exp 01/16/1", dout, count, full); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", ovf); end
    for (int i = 1; i <= 16; i++) begin
      total++; if (dout !== ((i == 16) ? 6'h2A : 6'(i))) begin bad++; $display("FAIL fullrw_drain%0d got=%h", i, dout); end
      cyc(0, 6'h00, 1, 0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 5; k++) cyc(1, 6'(k), 0, 0);
    for (int i = 0; i < 20; i++) begin
      total++; if (dout !== 6'(i)) begin bad++; $display("FAIL b2b_out%0d got=%h exp=%h", i, dout, 6'(i)); end
      cyc(1, 6'(i + 5), 1, 0);
      total++; if (count !== 5'd5) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=5", i, count); end
    end
    for (int i = 20; i < 25; i++) begin
      total++; if (dout !== 6'(i)) begin bad++; $display("FAIL b2b_tail%0d got=%h exp=%h", i, dout, 6'(i)); end
      cyc(0, 6'h00, 1, 0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_rd;
    cyc(0, 6'h00, 1, 0);
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL udf_count got count=%0d empty=%b exp 0/1", count, empty); end
    total++; if (udf !== ERR) begin bad++; $display("FAIL udf_set got=%b exp=%b", udf, ERR); end
    cyc(0, 6'h00, 0, 1);
    total++; if (udf !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b exp=0", udf); end
    cyc(0, 6'h00, 1, 1);
    total++; if (udf !== 1'b0) begin bad++; $display("FAIL udf_clr_prio got=%b exp=0", udf); end
    cyc(1, 6'h15, 1, 0);
    total++; if (count !== 5'd1 || dout !== 6'h15 || empty !== 1'b0) begin bad++; $display("FAIL empty_wrrd got count=%0d dout=%h empty=%b exp 1/15/0", count, dout, empty); end
    total++; if (udf !== ERR) begin bad++; $display("FAIL empty_wrrd_udf got=%b exp=%b", udf, ERR); end
    cyc(0, 6'h00, 1, 1);
    total++; if (empty !== 1'b1 || udf !== 1'b0) begin bad++; $display("FAIL empty_final got empty=%b udf=%b exp 1/0", empty, udf); end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 9; k++) cyc(1, 6'(k + 8), 0, 0);
    total++; if (count !== 5'd9) begin bad++; $display("FAIL rstmid_pre got=%0d exp=9", count); end
    wr = 1; din = 6'h33;
    #2 rst = 1;
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || afull !== 1'b0) begin bad++; $display("FAIL rstmid_async got count=%0d empty=%b afull=%b exp 0/1/0", count, empty, afull); end
    wr = 0;
    @(posedge clk); #1;
    rst = 0;
    cyc(1, 6'h07, 0, 0);
    total++; if (dout !== 6'h07 || count !== 5'd1 || empty !== 1'b0) begin bad++; $display("FAIL rstmid_after got dout=%h count=%0d empty=%b exp 07/1/0", dout, count, empty); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_full_rw;
    test_back_to_back;
    test_empty_rd;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
